// File: rtl/spi_avmm_burst_bridge_if.sv
// AVMM bus bundle shared by both sides of spi_avmm_burst_bridge.
// The master modport drives the command and the slave modport answers it.
// burstcount is present on both sides; the single-word side always drives 1.
interface spi_avmm_burst_bridge_if #(
  parameter int ADDR_W  = 17,
  parameter int DATA_W  = 32,
  parameter int BE_W    = 4,
  parameter int BURST_W = 9
) ();
  logic [ADDR_W-1:0]  address;
  logic               write;
  logic               read;
  logic [BURST_W-1:0] burstcount;
  logic [DATA_W-1:0]  writedata;
  logic [BE_W-1:0]    byteenable;
  logic               waitrequest;
  logic [DATA_W-1:0]  readdata;
  logic               readdatavalid;

  modport master (
    output address, write, read, burstcount, writedata, byteenable,
    input  waitrequest, readdata, readdatavalid
  );

  modport slave (
    input  address, write, read, burstcount, writedata, byteenable,
    output waitrequest, readdata, readdatavalid
  );
endinterface

// File: rtl/spi_avmm_burst_bridge.sv
// Burst-to-single AVMM bridge between the SPI slave's AVMM master and an AIB
// configuration AVMM slave. Bursts (up to 256 beats, 0 counts as 1) are split
// into single-word accesses at incrementing, wrapping byte addresses with one
// access outstanding. Read data returns in order, one cycle after the AIB
// strobe. The SPI side only ever sees registered waitrequest, so AIB stalls
// never reach it combinationally.
// Optional feature macro: SPI_AVMM_BRIDGE_TIMEOUT_EN enables the read-response
// timeout (returns 0xDEADBEEF and sets the sticky err_timeout flag).
module spi_avmm_burst_bridge #(
  parameter int ADDR_W      = 17,
  parameter int DATA_W      = 32,
  parameter int BE_W        = 4,
  parameter int BURST_W     = 9,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic                    avmm_clk,
  input  logic                    avmm_rst,
  spi_avmm_burst_bridge_if.slave  s,
  spi_avmm_burst_bridge_if.master m,
  output logic                    err_timeout
);

  localparam logic [1:0] IDLE     = 2'd0;
  localparam logic [1:0] WR_BURST = 2'd1;
  localparam logic [1:0] RD_ISSUE = 2'd2;
  localparam logic [1:0] RD_WAIT  = 2'd3;

  localparam logic [ADDR_W-1:0]  ADDR_STEP = ADDR_W'(BE_W);
  localparam logic [BURST_W-1:0] ONE_BEAT  = BURST_W'(1);

  logic [1:0]         state_reg;
  logic [BURST_W-1:0] beats_left_reg;
  logic               s_wait_reg;
  logic               s_rvalid_reg;
  logic [DATA_W-1:0]  s_rdata_reg;
  logic               m_write_reg;
  logic               m_read_reg;
  logic [ADDR_W-1:0]  m_addr_reg;
  logic [DATA_W-1:0]  m_wdata_reg;
  logic [BE_W-1:0]    m_be_reg;

  logic               s_wr_acc;
  logic               s_rd_acc;
  logic               m_acc;
  logic               rd_resp;
  logic [DATA_W-1:0]  rd_resp_data;
  logic [BURST_W-1:0] burst_len;
  logic [ADDR_W-1:0]  next_addr;

  // SPI-side acceptance uses the registered waitrequest; a write wins over a
  // simultaneous read, which simply stays pending on the bus.
  assign s_wr_acc  = !s_wait_reg && s.write;
  assign s_rd_acc  = !s_wait_reg && s.read && !s.write;
  assign m_acc     = !m.waitrequest;
  assign burst_len = (s.burstcount == '0) ? ONE_BEAT : s.burstcount;
  // Natural ADDR_W-bit overflow gives the modulo-2^ADDR_W wrap.
  assign next_addr = m_addr_reg + ADDR_STEP;

`ifdef SPI_AVMM_BRIDGE_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYC + 1);

  logic [TO_W-1:0] to_cnt_reg;
  logic            err_reg;
  logic            to_fire;

  assign to_fire = (state_reg == RD_WAIT) && !m.readdatavalid &&
                   (to_cnt_reg == TO_W'(TIMEOUT_CYC - 1));

  // Count cycles spent waiting for each read beat; flag sticks until reset.
  always_ff @(posedge avmm_clk) begin
    if (avmm_rst) begin
      to_cnt_reg <= '0;
      err_reg    <= 1'b0;
    end else begin
      if (state_reg != RD_WAIT || to_fire) begin
        to_cnt_reg <= '0;
      end else begin
        to_cnt_reg <= to_cnt_reg + TO_W'(1);
      end
      if (to_fire) begin
        err_reg <= 1'b1;
      end
    end
  end

  // A timed-out beat completes with a marker word; a late AIB strobe then
  // lands outside RD_WAIT of that beat and is dropped.
  assign rd_resp      = (state_reg == RD_WAIT) && (m.readdatavalid || to_fire);
  assign rd_resp_data = m.readdatavalid ? m.readdata : DATA_W'(32'hDEAD_BEEF);
  assign err_timeout  = err_reg;
`else
  assign rd_resp      = (state_reg == RD_WAIT) && m.readdatavalid;
  assign rd_resp_data = m.readdata;
  // No timeout hardware in this build: always 0 (TIMEOUT_CYC is never negative).
  assign err_timeout  = (TIMEOUT_CYC < 0);
`endif

  // Main FSM: splits bursts into single-word accesses and tracks beats left.
  always_ff @(posedge avmm_clk) begin
    if (avmm_rst) begin
      state_reg      <= IDLE;
      beats_left_reg <= '0;
      s_wait_reg     <= 1'b1;
      s_rvalid_reg   <= 1'b0;
      s_rdata_reg    <= '0;
      m_write_reg    <= 1'b0;
      m_read_reg     <= 1'b0;
      m_addr_reg     <= '0;
      m_wdata_reg    <= '0;
      m_be_reg       <= '0;
    end else begin
      s_rvalid_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          s_wait_reg <= 1'b0;
          if (s_wr_acc) begin
            m_write_reg    <= 1'b1;
            m_addr_reg     <= s.address;
            m_wdata_reg    <= s.writedata;
            m_be_reg       <= s.byteenable;
            beats_left_reg <= burst_len;
            s_wait_reg     <= 1'b1;
            state_reg      <= WR_BURST;
          end else if (s_rd_acc) begin
            m_read_reg     <= 1'b1;
            m_addr_reg     <= s.address;
            beats_left_reg <= burst_len;
            s_wait_reg     <= 1'b1;
            state_reg      <= RD_ISSUE;
          end
        end
        WR_BURST: begin
          if (m_write_reg) begin
            // Hold the beat until the AIB takes it, then open the SPI side
            // for exactly the following cycle.
            if (m_acc) begin
              m_write_reg    <= 1'b0;
              s_wait_reg     <= 1'b0;
              beats_left_reg <= beats_left_reg - ONE_BEAT;
              if (beats_left_reg == ONE_BEAT) begin
                state_reg <= IDLE;
              end
            end
          end else if (s_wr_acc) begin
            m_write_reg <= 1'b1;
            m_addr_reg  <= next_addr;
            m_wdata_reg <= s.writedata;
            m_be_reg    <= s.byteenable;
            s_wait_reg  <= 1'b1;
          end
        end
        RD_ISSUE: begin
          if (m_acc) begin
            m_read_reg <= 1'b0;
            state_reg  <= RD_WAIT;
          end
        end
        RD_WAIT: begin
          if (rd_resp) begin
            s_rdata_reg    <= rd_resp_data;
            s_rvalid_reg   <= 1'b1;
            beats_left_reg <= beats_left_reg - ONE_BEAT;
            if (beats_left_reg == ONE_BEAT) begin
              s_wait_reg <= 1'b0;
              state_reg  <= IDLE;
            end else begin
              m_addr_reg <= next_addr;
              m_read_reg <= 1'b1;
              state_reg  <= RD_ISSUE;
            end
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign s.waitrequest   = s_wait_reg;
  assign s.readdata      = s_rdata_reg;
  assign s.readdatavalid = s_rvalid_reg;

  assign m.address    = m_addr_reg;
  assign m.write      = m_write_reg;
  assign m.read       = m_read_reg;
  assign m.burstcount = ONE_BEAT;
  assign m.writedata  = m_wdata_reg;
  assign m.byteenable = m_be_reg;

endmodule

// File: tb/tb_spi_avmm_burst_bridge.sv
// Directed testbench for spi_avmm_burst_bridge: an SPI-side driver, an AIB
// responder answering each accepted read one cycle later, and per-scenario
// tasks comparing logged traffic against hand-computed values.
module tb_spi_avmm_burst_bridge;
  localparam int ADDR_W = 17, DATA_W = 32, BE_W = 4, BURST_W = 9, TIMEOUT_CYC = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic err_timeout;

  always #5 clk = ~clk;

  spi_avmm_burst_bridge_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .BE_W(BE_W), .BURST_W(BURST_W)) s_if ();
  spi_avmm_burst_bridge_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .BE_W(BE_W), .BURST_W(BURST_W)) m_if ();

  spi_avmm_burst_bridge #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .BE_W(BE_W), .BURST_W(BURST_W), .TIMEOUT_CYC(TIMEOUT_CYC)
  ) dut (
    .avmm_clk(clk), .avmm_rst(rst), .s(s_if), .m(m_if), .err_timeout(err_timeout)
  );

  int tests = 0;
  int fails = 0;
  int cyc = 0;

  logic [ADDR_W-1:0] wr_addr_q[$];
  logic [DATA_W-1:0] wr_data_q[$];
  logic [ADDR_W-1:0] rd_addr_q[$];
  logic [DATA_W-1:0] s_data_q[$];
  int                s_cyc_q[$];
  int                m_rdv_cyc_q[$];

  int                resp_budget = -1;   // -1: answer every read; n: answer n more
  logic [DATA_W-1:0] resp_val = '0;
  bit                stray_req = 1'b0;

  // Log handshakes at the edge; answer accepted reads one cycle later.
  always @(posedge clk) begin
    bit rd_acc;
    rd_acc = m_if.read && !m_if.waitrequest;
    if (m_if.write && !m_if.waitrequest) begin
      wr_addr_q.push_back(m_if.address);
      wr_data_q.push_back(m_if.writedata);
      $display("[TB] cyc %0d AIB write addr=%05h data=%08h", cyc, m_if.address, m_if.writedata);
    end
    if (rd_acc) begin
      rd_addr_q.push_back(m_if.address);
      $display("[TB] cyc %0d AIB read addr=%05h", cyc, m_if.address);
    end
    if (s_if.readdatavalid) begin
      s_data_q.push_back(s_if.readdata);
      s_cyc_q.push_back(cyc);
      $display("[TB] cyc %0d SPI readdata=%08h", cyc, s_if.readdata);
    end
    if (m_if.readdatavalid) m_rdv_cyc_q.push_back(cyc);
    cyc++;
    #1;
    m_if.readdatavalid = 1'b0;
    if (stray_req) begin
      m_if.readdatavalid = 1'b1;
      m_if.readdata      = 32'h5555_AAAA;
      stray_req          = 1'b0;
    end else if (rd_acc && resp_budget != 0) begin
      m_if.readdatavalid = 1'b1;
      m_if.readdata      = resp_val;
      resp_val           = resp_val + 1;
      if (resp_budget > 0) resp_budget--;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, required $finish before time limit");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_logs();
    wr_addr_q.delete(); wr_data_q.delete(); rd_addr_q.delete();
    s_data_q.delete(); s_cyc_q.delete(); m_rdv_cyc_q.delete();
  endtask

  task automatic spi_write_burst(input logic [ADDR_W-1:0] addr, input int n, input logic [BURST_W-1:0] bc,
                                 input logic [DATA_W-1:0] d0, input logic [DATA_W-1:0] dstep, output bit ok);
    bit stall;
    int w;
    ok = 1'b1;
    for (int i = 0; i < n; i++) begin
      s_if.write      = 1'b1;
      s_if.address    = addr;
      s_if.burstcount = bc;
      s_if.writedata  = d0 + DATA_W'(i) * dstep;
      s_if.byteenable = '1;
      w = 0;
      do begin stall = s_if.waitrequest; tick(); w++; end while (stall && w < 200);
      if (stall) ok = 1'b0;
    end
    s_if.write = 1'b0;
  endtask

  task automatic spi_read(input logic [ADDR_W-1:0] addr, input logic [BURST_W-1:0] bc, output bit ok);
    bit stall;
    int w;
    s_if.read       = 1'b1;
    s_if.address    = addr;
    s_if.burstcount = bc;
    w = 0;
    do begin stall = s_if.waitrequest; tick(); w++; end while (stall && w < 200);
    s_if.read = 1'b0;
    ok = !stall;
  endtask

  task automatic wait_srdv(input int n, output bit ok);
    int w;
    w = 0;
    while (s_data_q.size() < n && w < 500) begin tick(); w++; end
    ok = (s_data_q.size() >= n);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) tick();
    tests++; if (s_if.waitrequest !== 1'b1) begin fails++; $display("FAIL rst_s_waitrequest: got %b required 1", s_if.waitrequest); end
    tests++; if (s_if.readdatavalid !== 1'b0) begin fails++; $display("FAIL rst_s_readdatavalid: got %b required 0", s_if.readdatavalid); end
    tests++; if (s_if.readdata !== '0) begin fails++; $display("FAIL rst_s_readdata: got %h required 0", s_if.readdata); end
    tests++; if (m_if.write !== 1'b0 || m_if.read !== 1'b0) begin fails++; $display("FAIL rst_m_strobes: got write=%b read=%b required 0/0", m_if.write, m_if.read); end
    tests++; if (m_if.address !== '0 || m_if.writedata !== '0 || m_if.byteenable !== '0) begin
      fails++; $display("FAIL rst_m_regs: got addr=%h data=%h be=%h required all 0", m_if.address, m_if.writedata, m_if.byteenable); end
    tests++; if (err_timeout !== 1'b0) begin fails++; $display("FAIL rst_err_timeout: got %b required 0", err_timeout); end
    rst = 1'b0;
    tick();
    tests++; if (s_if.waitrequest !== 1'b0) begin fails++; $display("FAIL rst_idle_ready: got s_waitrequest=%b required 0", s_if.waitrequest); end
  endtask

  task automatic test_write_burst();
    bit ok;
    clear_logs();
    spi_write_burst(17'h00200, 4, 9'd4, 32'h11, 32'h11, ok);
    repeat (4) tick();
    tests++; if (!ok) begin fails++; $display("FAIL wr_accept: got timeout required 4 beats accepted"); end
    tests++; if (wr_addr_q.size() != 4) begin fails++; $display("FAIL wr_count: got %0d required 4", wr_addr_q.size()); end
    for (int i = 0; i < 4 && i < wr_addr_q.size(); i++) begin
      tests++;
      if (wr_addr_q[i] !== 17'h00200 + 17'(4 * i) || wr_data_q[i] !== 32'(8'h11 * (i + 1))) begin
        fails++; $display("FAIL wr_beat%0d: got addr=%h data=%h required addr=%h data=%h", i,
                          wr_addr_q[i], wr_data_q[i], 17'h00200 + 17'(4 * i), 32'(8'h11 * (i + 1)));
      end
    end
    tests++; if (s_if.waitrequest !== 1'b0) begin fails++; $display("FAIL wr_back_idle: got s_waitrequest=%b required 0", s_if.waitrequest); end
  endtask

  task automatic test_read_burst();
    bit ok, ok2;
    clear_logs();
    resp_budget = -1;
    resp_val = 32'hA0;
    spi_read(17'h01000, 9'd3, ok);
    tests++; if (!ok || s_if.waitrequest !== 1'b1) begin fails++; $display("FAIL rd_busy: got accepted=%b s_waitrequest=%b required 1/1", ok, s_if.waitrequest); end
    wait_srdv(3, ok2);
    repeat (5) tick();
    tests++; if (!ok2 || s_data_q.size() != 3) begin fails++; $display("FAIL rd_count: got %0d required 3", s_data_q.size()); end
    for (int i = 0; i < 3 && i < s_data_q.size() && i < rd_addr_q.size() && i < m_rdv_cyc_q.size(); i++) begin
      tests++;
      if (s_data_q[i] !== 32'hA0 + 32'(i) || rd_addr_q[i] !== 17'h01000 + 17'(4 * i) || s_cyc_q[i] != m_rdv_cyc_q[i] + 1) begin
        fails++; $display("FAIL rd_beat%0d: got data=%h addr=%h lat=%0d required data=%h addr=%h lat=1", i, s_data_q[i],
                          rd_addr_q[i], s_cyc_q[i] - m_rdv_cyc_q[i], 32'hA0 + 32'(i), 17'h01000 + 17'(4 * i));
      end
    end
  endtask

  task automatic test_backpressure();
    bit ok, found;
    int bad;
    logic [ADDR_W-1:0] a0;
    logic [DATA_W-1:0] d0;
    clear_logs();
    found = 1'b0;
    bad = 0;
    fork
      spi_write_burst(17'h00300, 4, 9'd4, 32'hB0, 32'h1, ok);
      begin
        for (int w = 0; w < 100 && !found; w++) begin
          if (m_if.write && m_if.address == 17'h00304) found = 1'b1;
          else tick();
        end
        if (found) begin
          m_if.waitrequest = 1'b1;
          a0 = m_if.address;
          d0 = m_if.writedata;
          for (int k = 0; k < 5; k++) begin
            tick();
            if (m_if.write !== 1'b1 || m_if.address !== a0 || m_if.writedata !== d0 || s_if.waitrequest !== 1'b1) bad++;
          end
          m_if.waitrequest = 1'b0;
        end
      end
    join
    repeat (4) tick();
    tests++; if (!found) begin fails++; $display("FAIL bp_beat2_seen: got none required beat at 00304"); end
    tests++; if (bad != 0) begin fails++; $display("FAIL bp_stable: got %0d unstable stall cycles required 0", bad); end
    tests++; if (!ok || wr_addr_q.size() != 4) begin fails++; $display("FAIL bp_count: got %0d required 4", wr_addr_q.size()); end
    for (int i = 0; i < 4 && i < wr_addr_q.size(); i++) begin
      tests++;
      if (wr_addr_q[i] !== 17'h00300 + 17'(4 * i) || wr_data_q[i] !== 32'hB0 + 32'(i)) begin
        fails++; $display("FAIL bp_beat%0d: got addr=%h data=%h required addr=%h data=%h", i, wr_addr_q[i], wr_data_q[i],
                          17'h00300 + 17'(4 * i), 32'hB0 + 32'(i));
      end
    end
  endtask

  task automatic test_wrap_zero();
    bit ok, ok2;
    clear_logs();
    spi_read(17'h1FFFC, 9'd2, ok);
    wait_srdv(2, ok2);
    repeat (5) tick();
    tests++; if (!ok2 || rd_addr_q.size() != 2) begin fails++; $display("FAIL wrap_count: got %0d required 2", rd_addr_q.size()); end
    else begin
      tests++; if (rd_addr_q[0] !== 17'h1FFFC || rd_addr_q[1] !== 17'h00000) begin
        fails++; $display("FAIL wrap_addr: got %h,%h required 1fffc,00000", rd_addr_q[0], rd_addr_q[1]); end
    end
    clear_logs();
    spi_read(17'h00040, 9'd0, ok);
    wait_srdv(1, ok2);
    repeat (10) tick();
    tests++; if (rd_addr_q.size() != 1 || s_data_q.size() != 1) begin
      fails++; $display("FAIL zero_rd: got %0d reads %0d returns required 1/1", rd_addr_q.size(), s_data_q.size()); end
    clear_logs();
    spi_write_burst(17'h00080, 1, 9'd0, 32'h0000_0080, 32'h0, ok);
    repeat (10) tick();
    tests++; if (wr_addr_q.size() != 1 || s_if.waitrequest !== 1'b0) begin
      fails++; $display("FAIL zero_wr: got %0d writes wait=%b required 1 write, idle", wr_addr_q.size(), s_if.waitrequest); end
  endtask

  task automatic test_priority();
    bit stall, ok;
    int w;
    clear_logs();
    s_if.write = 1'b1; s_if.read = 1'b1; s_if.address = 17'h00500;
    s_if.burstcount = 9'd1; s_if.writedata = 32'hC0; s_if.byteenable = '1;
    w = 0;
    do begin stall = s_if.waitrequest; tick(); w++; end while (stall && w < 200);
    s_if.write = 1'b0;
    tests++; if (stall || m_if.read !== 1'b0 || m_if.write !== 1'b1) begin
      fails++; $display("FAIL prio_write_first: got m_write=%b m_read=%b required 1/0", m_if.write, m_if.read); end
    w = 0;
    do begin stall = s_if.waitrequest; tick(); w++; end while (stall && w < 200);
    s_if.read = 1'b0;
    wait_srdv(1, ok);
    repeat (5) tick();
    tests++; if (wr_addr_q.size() != 1 || rd_addr_q.size() != 1 || s_data_q.size() != 1) begin
      fails++; $display("FAIL prio_counts: got wr=%0d rd=%0d ret=%0d required 1/1/1", wr_addr_q.size(), rd_addr_q.size(), s_data_q.size()); end
  endtask

  task automatic test_stray_rdv();
    clear_logs();
    stray_req = 1'b1;
    repeat (5) tick();
    tests++; if (s_data_q.size() != 0) begin fails++; $display("FAIL stray_rdv: got %0d returns required 0", s_data_q.size()); end
  endtask

  task automatic test_reset_mid_read();
    bit ok;
    int w;
    clear_logs();
    resp_budget = 1;
    resp_val = 32'hE0;
    spi_read(17'h02000, 9'd4, ok);
    w = 0;
    while (rd_addr_q.size() < 2 && w < 100) begin tick(); w++; end
    tick();
    tests++; if (rd_addr_q.size() != 2 || s_data_q.size() != 1) begin
      fails++; $display("FAIL mid_rd_setup: got %0d reads %0d returns required 2/1", rd_addr_q.size(), s_data_q.size()); end
    rst = 1'b1;
    tick();
    tests++; if (m_if.read !== 1'b0 || s_if.waitrequest !== 1'b1 || s_if.readdatavalid !== 1'b0) begin
      fails++; $display("FAIL mid_rd_reset: got m_read=%b s_wait=%b s_rdv=%b required 0/1/0", m_if.read, s_if.waitrequest, s_if.readdatavalid); end
    rst = 1'b0;
    resp_budget = -1;
    tick();
    tests++; if (s_if.waitrequest !== 1'b0) begin fails++; $display("FAIL mid_rd_idle: got s_waitrequest=%b required 0", s_if.waitrequest); end
    clear_logs();
    spi_write_burst(17'h00600, 2, 9'd2, 32'h61, 32'h1, ok);
    repeat (6) tick();
    tests++; if (wr_addr_q.size() != 2 || rd_addr_q.size() != 0) begin
      fails++; $display("FAIL post_rst_wr_count: got wr=%0d rd=%0d required 2/0", wr_addr_q.size(), rd_addr_q.size()); end
    else begin
      tests++; if (wr_addr_q[1] !== 17'h00604 || wr_data_q[1] !== 32'h62 || wr_addr_q[0] !== 17'h00600) begin
        fails++; $display("FAIL post_rst_wr: got %h/%h,%h required 00600/00604,62", wr_addr_q[0], wr_addr_q[1], wr_data_q[1]); end
    end
  endtask

`ifdef SPI_AVMM_BRIDGE_TIMEOUT_EN
  task automatic test_timeout();
    bit ok, ok2;
    int t0;
    clear_logs();
    resp_budget = 0;
    spi_read(17'h00700, 9'd2, ok);
    t0 = cyc;
    wait_srdv(2, ok2);
    tests++; if (!ok2 || s_data_q[0] !== 32'hDEAD_BEEF || s_data_q[1] !== 32'hDEAD_BEEF) begin
      fails++; $display("FAIL to_data: got %0d returns first=%h required 2 x deadbeef", s_data_q.size(), s_data_q[0]); end
    tests++; if (s_cyc_q.size() == 0 || s_cyc_q[0] - t0 < TIMEOUT_CYC) begin
      fails++; $display("FAIL to_delay: got %0d cycles required >= %0d", s_cyc_q.size() ? s_cyc_q[0] - t0 : 0, TIMEOUT_CYC); end
    tests++; if (err_timeout !== 1'b1) begin fails++; $display("FAIL to_flag: got %b required 1", err_timeout); end
    clear_logs();
    resp_budget = -1;
    resp_val = 32'h77;
    spi_read(17'h00710, 9'd1, ok);
    wait_srdv(1, ok2);
    repeat (3) tick();
    tests++; if (!ok2 || s_data_q[0] !== 32'h77 || err_timeout !== 1'b1) begin
      fails++; $display("FAIL to_sticky: got data=%h err=%b required 77/1", s_data_q[0], err_timeout); end
  endtask
`endif

  initial begin
    s_if.write = 1'b0; s_if.read = 1'b0; s_if.address = '0; s_if.burstcount = '0;
    s_if.writedata = '0; s_if.byteenable = '0;
    m_if.waitrequest = 1'b0;
    test_reset();
    test_write_burst();
    test_read_burst();
    test_backpressure();
    test_wrap_zero();
    test_priority();
    test_stray_rdv();
    test_reset_mid_read();
`ifdef SPI_AVMM_BRIDGE_TIMEOUT_EN
    test_timeout();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/spi_avmm_burst_bridge.md
Name: spi_avmm_burst_bridge

Overview:
- Sits between the SPI slave's AVMM master side and an AIB model's configuration AVMM slave (avmm_if_sspi0/1/2 path).
- Converts SPI-originated burst AVMM commands (burstcount up to 256) into single-word AVMM accesses with incrementing addresses, one access outstanding at a time.
- Returns read data to the SPI slave in order and isolates the SPI side from AIB waitrequest stalls.

Parameters:
- ADDR_W, 17, AVMM byte-address width, both sides
- DATA_W, 32, AVMM data width
- BE_W, 4, byte-enable width (DATA_W/8)
- BURST_W, 9, burstcount width (max 256 beats)
- TIMEOUT_CYC, 1024, read-response timeout in cycles (optional feature only)

Ports:
- avmm_clk  in  1  clock; all logic on rising edge
- avmm_rst  in  1  synchronous, active-high reset
- s_address  in  ADDR_W  burst start byte address from SPI slave
- s_write  in  1  write request, one per beat
- s_read  in  1  read command, one per burst
- s_burstcount  in  BURST_W  beats in burst
- s_writedata  in  DATA_W  write beat data
- s_byteenable  in  BE_W  write beat byte enables
- s_waitrequest  out  1  stall to SPI slave
- s_readdata  out  DATA_W  read data to SPI slave
- s_readdatavalid  out  1  read data strobe
- m_address  out  ADDR_W  single-word address to AIB
- m_write  out  1  write strobe to AIB
- m_read  out  1  read strobe to AIB
- m_writedata  out  DATA_W  write data to AIB
- m_byteenable  out  BE_W  byte enables to AIB
- m_waitrequest  in  1  AIB stall
- m_readdata  in  DATA_W  AIB read data
- m_readdatavalid  in  1  AIB read data strobe
- err_timeout  out  1  sticky timeout flag (optional feature)

Behaviour:
- Reset values:
  - s_waitrequest=1; s_readdatavalid=0; s_readdata=0
  - m_write=0; m_read=0; m_address=0; m_writedata=0; m_byteenable=0
  - err_timeout=0; FSM=IDLE; beat counter=0
- Reset applies mid-burst: FSM returns to IDLE and all m_*/s_* strobes deassert in the next cycle. Abandoned beats are not replayed.
- FSM states: IDLE, WR_BURST, RD_ISSUE, RD_WAIT.
- IDLE:
  - s_waitrequest=0.
  - s_write accepted: latch address and burstcount; load the beat into the m_* register (m_write=1); go to WR_BURST.
  - s_read accepted: latch address and burstcount; go to RD_ISSUE.
  - s_write and s_read both high: write has priority; the read stays pending on the bus.
  - burstcount=0 is treated as 1.
- WR_BURST:
  - m_write is held with stable address/data/byteenable until a cycle with m_waitrequest=0.
  - s_waitrequest=0 only in the cycle after the m_* register empties, so sustained throughput is at most one beat per 2 cycles.
  - Each accepted beat takes address = previous address + BE_W.
  - After the last beat completes downstream, go to IDLE.
- RD_ISSUE:
  - m_read=1 with current address until m_waitrequest=0, then go to RD_WAIT with m_read=0.
- RD_WAIT:
  - On m_readdatavalid, register m_readdata into s_readdata; s_readdatavalid pulses 1 cycle later (latency 1).
  - Decrement remaining count. If nonzero, address += BE_W and go to RD_ISSUE; else go to IDLE.
  - s_waitrequest=1 throughout the read burst.
- Address arithmetic is modulo 2^ADDR_W: 0x1FFFC + 4 wraps to 0x00000.
- m_readdatavalid outside RD_WAIT is ignored and not forwarded.
- Exactly burstcount strobes are produced on each side; no other strobes are ever generated.

Optional Feature:
- Macro: SPI_AVMM_BRIDGE_TIMEOUT_EN.
- Defined:
  - RD_WAIT counts cycles. If TIMEOUT_CYC elapse with no m_readdatavalid, the bridge returns 0xDEAD_BEEF as that beat's s_readdata, sets err_timeout (sticky until reset), and continues the burst normally.
  - A late m_readdatavalid arriving afterwards is dropped.
- Not defined:
  - No counter; RD_WAIT waits indefinitely.
  - err_timeout is tied 0.

Test Plan:
- Write burst: addr 0x00200, burstcount 4, data 0x11..0x44, m_waitrequest=0 → m_write beats at 0x200/0x204/0x208/0x20C with matching data; return to IDLE.
- Read burst: addr 0x01000, burstcount 3, AIB returns 0xA0/0xA1/0xA2 → three s_readdatavalid pulses in order, each 1 cycle after its m_readdatavalid.
- Backpressure: m_waitrequest held high 5 cycles on beat 2 of a write → m_* signals stable throughout, s_waitrequest=1, no beat lost or duplicated.
- Wrap and zero count:
  - Read at 0x1FFFC with burstcount 2 → accesses 0x1FFFC then 0x00000.
  - burstcount=0 → exactly one access.
- Reset mid-read (during RD_WAIT of beat 2 of 4) → next cycle m_read=0, s_waitrequest=1, FSM in IDLE; a new write burst afterwards completes correctly.
- With SPI_AVMM_BRIDGE_TIMEOUT_EN and TIMEOUT_CYC=16, AIB never responds → s_readdata=0xDEADBEEF after 16 cycles; err_timeout=1 and stays 1 through later good transfers.
